// File: rtl/fwd_opti_pkg.sv
// opti_pkg: shared types and constants for the fwd_opti forwarding block.
//   REG_IDX_W   register index width
//   ENTRY_XLEN  width of the data field carried in each tracked stage
//   SRC_RF      forward-source code meaning "register file"
//   fwd_entry_t one tracked pending-writeback stage
package opti_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int ENTRY_XLEN = 32;
    localparam int SRC_RF     = 0;

    typedef struct packed {
        logic                  valid;
        logic [REG_IDX_W-1:0]  rd;
        logic                  is_load;
        logic                  ready;
        logic [ENTRY_XLEN-1:0] data;
    } fwd_entry_t;

    localparam fwd_entry_t FWD_BUBBLE = '0;

    // x0 is hardwired, so an entry targeting it never produces a value.
    function automatic logic is_writer(input fwd_entry_t e);
        return e.valid && (e.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// fwd_match: combinational priority matcher for one source operand.
// Picks the youngest (lowest index) stage writing the requested register.
//   stages   in   tracked stage entries, index 0 = youngest
//   rs       in   source register index
//   rf_data  in   register-file read data for rs
//   value    out  forwarded operand (rf_data when nothing matches)
//   src      out  0 = register file, k+1 = stage Sk
//   hazard   out  the matching stage holds a result that is not ready yet
module fwd_match
    import opti_pkg::*;
#(
    parameter int NFWD = 3,
    parameter int XLEN = 32,
    parameter int SRCW = $clog2(NFWD + 1)
) (
    input  fwd_entry_t [NFWD-1:0] stages,
    input  logic [REG_IDX_W-1:0]  rs,
    input  logic [XLEN-1:0]       rf_data,
    output logic [XLEN-1:0]       value,
    output logic [SRCW-1:0]       src,
    output logic                  hazard
);

    logic found;
    logic load_flags_unused;

    always_comb begin
        value  = rf_data;
        src    = SRCW'(SRC_RF);
        hazard = 1'b0;
        found  = 1'b0;
        for (int k = 0; k < NFWD; k++) begin
            if (!found && is_writer(stages[k]) && (stages[k].rd == rs)) begin
                found = 1'b1;
                src   = SRCW'(k + 1);
                if (stages[k].ready) begin
                    value = stages[k].data[XLEN-1:0];
                end else begin
                    hazard = 1'b1;
                end
            end
        end
    end

    // is_load only steers the shift pipeline; readiness is all the matcher needs.
    always_comb begin
        load_flags_unused = 1'b0;
        for (int k = 0; k < NFWD; k++) begin
            load_flags_unused = load_flags_unused ^ stages[k].is_load;
        end
    end

endmodule

// File: rtl/fwd_opti.sv
// fwd_opti: operand forwarding, load-use hazard detection and writeback
// drive for the RV32 pipeline, between decode/regfile and ALU/memory.
//   clk, rst                    clock, async active-high reset
//   ex_*                        execute-stage instruction description
//   flush                       kill the execute-stage instruction
//   a_sel, b_sel                operand source selects (pc / imm)
//   rf_rs1, rf_rs2, pc, imm     candidate operand values
//   ex_result, mem_rdata        ALU result in EX, load data for S0
//   brun                        unsigned branch compare
//   reg1, reg2, data_w          ALU operands and store data
//   breq, brlt                  branch compare of forwarded operands
//   stall                       hold fetch/decode/execute
//   fwd1_src, fwd2_src          forward-source debug codes
//   wb_en, wb_rd, wb_data       register-file writeback from S[NFWD-1]
module fwd_opti
    import opti_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NFWD = 3,
    parameter int SRCW = $clog2(NFWD + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic [REG_IDX_W-1:0] ex_rs1,
    input  logic [REG_IDX_W-1:0] ex_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_wen,
    input  logic                 ex_is_load,
    input  logic                 flush,
    input  logic                 a_sel,
    input  logic                 b_sel,
    input  logic [XLEN-1:0]      rf_rs1,
    input  logic [XLEN-1:0]      rf_rs2,
    input  logic [XLEN-1:0]      pc,
    input  logic [XLEN-1:0]      imm,
    input  logic [XLEN-1:0]      ex_result,
    input  logic [XLEN-1:0]      mem_rdata,
    input  logic                 brun,
    output logic [XLEN-1:0]      reg1,
    output logic [XLEN-1:0]      reg2,
    output logic [XLEN-1:0]      data_w,
    output logic                 breq,
    output logic                 brlt,
    output logic                 stall,
    output logic [SRCW-1:0]      fwd1_src,
    output logic [SRCW-1:0]      fwd2_src,
    output logic                 wb_en,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [XLEN-1:0]      wb_data
);

    fwd_entry_t [NFWD-1:0] st_q;
    fwd_entry_t [NFWD-1:0] st_d;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            haz_rs1;
    logic            haz_rs2;

    fwd_match #(.NFWD(NFWD), .XLEN(XLEN), .SRCW(SRCW)) u_match_rs1 (
        .stages  (st_q),
        .rs      (ex_rs1),
        .rf_data (rf_rs1),
        .value   (fwd_rs1),
        .src     (fwd1_src),
        .hazard  (haz_rs1)
    );

    fwd_match #(.NFWD(NFWD), .XLEN(XLEN), .SRCW(SRCW)) u_match_rs2 (
        .stages  (st_q),
        .rs      (ex_rs2),
        .rf_data (rf_rs2),
        .value   (fwd_rs2),
        .src     (fwd2_src),
        .hazard  (haz_rs2)
    );

    // rs2 hazard stalls even with b_sel=1: store data and branch compare use it.
    assign stall = ex_valid && !flush && (haz_rs1 || haz_rs2);

    assign reg1   = a_sel ? pc  : fwd_rs1;
    assign reg2   = b_sel ? imm : fwd_rs2;
    assign data_w = fwd_rs2;
    assign breq   = (fwd_rs1 == fwd_rs2);
    assign brlt   = brun ? (fwd_rs1 < fwd_rs2) : ($signed(fwd_rs1) < $signed(fwd_rs2));

    always_comb begin
        st_d = st_q;

        if (stall || flush || !ex_valid || !ex_wen) begin
            st_d[0] = FWD_BUBBLE;
        end else begin
            st_d[0].valid   = 1'b1;
            st_d[0].rd      = ex_rd;
            st_d[0].is_load = ex_is_load;
            st_d[0].ready   = !ex_is_load;
            st_d[0].data    = ENTRY_XLEN'(ex_result);
        end

        for (int k = 1; k < NFWD; k++) begin
            st_d[k] = st_q[k-1];
        end

        // Load data arrives while the load sits in S0 and is captured into S1.
        if (st_q[0].is_load) begin
            st_d[1].data  = ENTRY_XLEN'(mem_rdata);
            st_d[1].ready = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    assign wb_en   = is_writer(st_q[NFWD-1]);
    assign wb_rd   = st_q[NFWD-1].rd;
    assign wb_data = st_q[NFWD-1].data[XLEN-1:0];

endmodule

// File: tb/tb_fwd_opti.sv
module tb_fwd_opti;

    localparam int XLEN = 32;
    localparam int NFWD = 3;
    localparam int SRCW = $clog2(NFWD + 1);

    logic            clk;
    logic            rst;
    logic            ex_valid;
    logic [4:0]      ex_rs1, ex_rs2, ex_rd;
    logic            ex_wen, ex_is_load, flush, a_sel, b_sel, brun;
    logic [XLEN-1:0] rf_rs1, rf_rs2, pc, imm, ex_result, mem_rdata;
    logic [XLEN-1:0] reg1, reg2, data_w, wb_data;
    logic            breq, brlt, stall, wb_en;
    logic [SRCW-1:0] fwd1_src, fwd2_src;
    logic [4:0]      wb_rd;

    fwd_opti #(.XLEN(XLEN), .NFWD(NFWD)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .flush(flush),
        .a_sel(a_sel), .b_sel(b_sel), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .pc(pc),
        .imm(imm), .ex_result(ex_result), .mem_rdata(mem_rdata), .brun(brun),
        .reg1(reg1), .reg2(reg2), .data_w(data_w), .breq(breq), .brlt(brlt),
        .stall(stall), .fwd1_src(fwd1_src), .fwd2_src(fwd2_src), .wb_en(wb_en),
        .wb_rd(wb_rd), .wb_data(wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: history of what entered the tracked pipeline,
    // hist[k] = instruction that entered k+1 edges ago.
    typedef struct {
        bit        v;
        bit [4:0]  rd;
        bit        ld;
        bit [31:0] data;
    } rec_t;

    rec_t hist [NFWD];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void mdl_clear();
        for (int k = 0; k < NFWD; k++) begin
            hist[k] = '{v: 1'b0, rd: 5'd0, ld: 1'b0, data: 32'd0};
        end
    endfunction

    function automatic void mdl_fwd(input bit [4:0] rs, input bit [31:0] rf,
                                    output bit [31:0] val, output int src, output bit haz);
        val = rf;
        src = 0;
        haz = 1'b0;
        if (rs != 5'd0) begin
            for (int k = 0; k < NFWD; k++) begin
                if (hist[k].v && hist[k].rd == rs) begin
                    src = k + 1;
                    // A load's data only exists once it has left S0.
                    haz = hist[k].ld && (k == 0);
                    val = hist[k].data;
                    return;
                end
            end
        end
    endfunction

    function automatic bit mdl_stall();
        bit [31:0] v;
        int        s;
        bit        h1, h2;
        mdl_fwd(ex_rs1, rf_rs1, v, s, h1);
        mdl_fwd(ex_rs2, rf_rs2, v, s, h2);
        return ex_valid && !flush && (h1 || h2);
    endfunction

    task automatic check_all();
        bit [31:0] v1, v2;
        int        s1, s2;
        bit        h1, h2, lt, en;
        mdl_fwd(ex_rs1, rf_rs1, v1, s1, h1);
        mdl_fwd(ex_rs2, rf_rs2, v2, s2, h2);
        chk("stall", 32'(stall), 32'(ex_valid && !flush && (h1 || h2)));
        chk("fwd1_src", 32'(fwd1_src), 32'(s1));
        chk("fwd2_src", 32'(fwd2_src), 32'(s2));
        if (!h1 || a_sel) chk("reg1", reg1, a_sel ? pc : v1);
        if (!h2 || b_sel) chk("reg2", reg2, b_sel ? imm : v2);
        if (!h2) chk("data_w", data_w, v2);
        if (!h1 && !h2) begin
            lt = brun ? (v1 < v2) : ($signed(v1) < $signed(v2));
            chk("breq", 32'(breq), 32'(v1 == v2));
            chk("brlt", 32'(brlt), 32'(lt));
        end
        en = hist[NFWD-1].v && hist[NFWD-1].rd != 5'd0;
        chk("wb_en", 32'(wb_en), 32'(en));
        if (en) begin
            chk("wb_rd", 32'(wb_rd), 32'(hist[NFWD-1].rd));
            chk("wb_data", wb_data, hist[NFWD-1].data);
        end
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic tick();
        bit st;
        st = mdl_stall();
        @(posedge clk);
        if (rst) begin
            mdl_clear();
        end else begin
            if (hist[0].v && hist[0].ld) hist[0].data = mem_rdata;
            for (int k = NFWD - 1; k >= 1; k--) hist[k] = hist[k-1];
            if (st || flush || !ex_valid || !ex_wen)
                hist[0] = '{v: 1'b0, rd: 5'd0, ld: 1'b0, data: 32'd0};
            else
                hist[0] = '{v: 1'b1, rd: ex_rd, ld: ex_is_load, data: ex_result};
        end
        #1;
    endtask

    task automatic issue(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                         input bit [4:0] rd, input bit wen, input bit ld, input bit [31:0] res);
        ex_valid   = v;
        ex_rs1     = rs1;
        ex_rs2     = rs2;
        ex_rd      = rd;
        ex_wen     = wen;
        ex_is_load = ld;
        ex_result  = res;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        issue(0, 0, 0, 0, 0, 0, 0);
        flush = 0; a_sel = 0; b_sel = 0; brun = 0;
        rf_rs1 = 32'h11; rf_rs2 = 32'h22; pc = 32'h400; imm = 32'h4;
        mem_rdata = 0;
        mdl_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        chk("rst_reg1", reg1, 32'h11);
        chk("rst_reg2", reg2, 32'h22);
        chk("rst_data_w", data_w, 32'h22);
        chk("rst_wb_en", 32'(wb_en), 0);
        chk("rst_wb_rd", 32'(wb_rd), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_stall", 32'(stall), 0);
        tick();

        // Reset asserted mid-stall with live entries.
        issue(1, 0, 0, 6, 1, 1, 32'h1000);
        settle(); check_all(); tick();
        issue(1, 6, 0, 9, 1, 0, 32'h1);
        settle(); check_all();
        chk("pre_rst_stall", 32'(stall), 1);
        rst = 1'b1;
        #1;
        mdl_clear();
        chk("mid_rst_stall", 32'(stall), 0);
        chk("mid_rst_src1", 32'(fwd1_src), 0);
        chk("mid_rst_reg1", reg1, rf_rs1);
        chk("mid_rst_wb_en", 32'(wb_en), 0);
        #1;
        rst = 1'b0;
        issue(1, 1, 2, 5, 1, 0, 32'h12);
        rf_rs1 = 7; rf_rs2 = 9;
        settle(); check_all();
        chk("add_reg1", reg1, 7);
        chk("add_reg2", reg2, 9);
        chk("add_src1", 32'(fwd1_src), 0);
        chk("add_stall", 32'(stall), 0);
        tick();

        // ALU back-to-back forwarding, then writeback three edges after entry.
        issue(1, 0, 0, 3, 1, 0, 32'h10);
        settle(); check_all(); tick();
        issue(1, 3, 0, 0, 0, 0, 32'h0);
        settle(); check_all();
        chk("b2b_reg1", reg1, 32'h10);
        chk("b2b_src1", 32'(fwd1_src), 1);
        tick();
        issue(0, 0, 0, 0, 0, 0, 0);
        settle(); check_all(); tick();
        settle(); check_all();
        chk("b2b_wb_en", 32'(wb_en), 1);
        chk("b2b_wb_rd", 32'(wb_rd), 3);
        chk("b2b_wb_data", wb_data, 32'h10);
        tick();

        // Youngest writer wins.
        issue(1, 0, 0, 4, 1, 0, 32'hA);
        settle(); check_all(); tick();
        issue(1, 0, 0, 4, 1, 0, 32'hB);
        settle(); check_all(); tick();
        issue(1, 0, 4, 0, 0, 0, 0);
        settle(); check_all();
        chk("young_reg2", reg2, 32'hB);
        chk("young_src2", 32'(fwd2_src), 1);
        tick();

        // Load-use: one stall cycle, then forward from S1; the bubble shows at writeback.
        issue(1, 0, 0, 6, 1, 1, 32'hDEAD);
        settle(); check_all(); tick();
        issue(1, 6, 0, 9, 1, 0, 32'h99);
        mem_rdata = 32'h55;
        settle(); check_all();
        chk("lu_stall", 32'(stall), 1);
        tick();
        mem_rdata = 32'hBAD;
        settle(); check_all();
        chk("lu_stall_drop", 32'(stall), 0);
        chk("lu_reg1", reg1, 32'h55);
        chk("lu_src1", 32'(fwd1_src), 2);
        tick();
        issue(0, 0, 0, 0, 0, 0, 0);
        settle(); check_all();
        chk("lu_wb_rd", 32'(wb_rd), 6);
        chk("lu_wb_data", wb_data, 32'h55);
        tick();
        settle(); check_all();
        chk("lu_bubble_wb", 32'(wb_en), 0);
        tick();
        settle(); check_all();
        chk("lu_wb_rd9", 32'(wb_rd), 9);
        chk("lu_wb_data9", wb_data, 32'h99);
        tick();

        // x0 never forwards.
        issue(1, 0, 0, 0, 1, 0, 32'h77);
        settle(); check_all(); tick();
        issue(1, 0, 0, 0, 0, 0, 0);
        rf_rs1 = 32'h123;
        settle(); check_all();
        chk("x0_src1", 32'(fwd1_src), 0);
        chk("x0_reg1", reg1, 32'h123);
        tick();

        // Flush beats hazard and inserts a bubble.
        issue(1, 0, 0, 6, 1, 1, 32'h0);
        settle(); check_all(); tick();
        issue(1, 6, 0, 10, 1, 0, 32'hAA);
        flush = 1;
        mem_rdata = 32'h66;
        settle(); check_all();
        chk("fl_stall", 32'(stall), 0);
        tick();
        flush = 0;
        issue(1, 6, 10, 0, 0, 0, 0);
        rf_rs2 = 32'h5A5;
        settle(); check_all();
        chk("fl_src1", 32'(fwd1_src), 2);
        chk("fl_reg1", reg1, 32'h66);
        chk("fl_src2", 32'(fwd2_src), 0);
        tick();

        // Branch and store on forwarded operands.
        issue(1, 0, 0, 7, 1, 0, 32'hFFFF_FFFF);
        settle(); check_all(); tick();
        issue(1, 0, 0, 8, 1, 0, 32'h1);
        settle(); check_all(); tick();
        issue(1, 7, 8, 0, 0, 0, 0);
        b_sel = 1; imm = 4; brun = 0;
        settle(); check_all();
        chk("br_s_brlt", 32'(brlt), 1);
        chk("br_s_data_w", data_w, 1);
        chk("br_s_reg2", reg2, 4);
        brun = 1;
        #1;
        check_all();
        chk("br_u_brlt", 32'(brlt), 0);
        chk("br_u_data_w", data_w, 1);
        chk("br_u_reg2", reg2, 4);
        tick();

        // Randomised traffic on a small register window to provoke overlaps.
        for (int i = 0; i < 400; i++) begin
            issue($urandom_range(7, 0) != 0, 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
                  5'($urandom_range(7, 0)), $urandom_range(3, 0) != 0,
                  $urandom_range(2, 0) == 0, $urandom);
            flush     = $urandom_range(7, 0) == 0;
            a_sel     = 1'($urandom_range(1, 0));
            b_sel     = 1'($urandom_range(1, 0));
            brun      = 1'($urandom_range(1, 0));
            rf_rs1    = $urandom;
            rf_rs2    = ($urandom_range(3, 0) == 0) ? rf_rs1 : $urandom;
            pc        = $urandom;
            imm       = $urandom;
            mem_rdata = $urandom;
            settle();
            check_all();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
